// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter that loads the winner's word and streams it MSB first
// through a DEPTH-stage serial chain. Define SHIFT_ARB_PARITY_EN to append an even-parity bit.
module shift_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             q,
  output logic             q_valid,
  output logic             done
);

`ifdef SHIFT_ARB_PARITY_EN
  localparam int unsigned SW = WIDTH + 1;
`else
  localparam int unsigned SW = WIDTH;
`endif
  localparam int unsigned CW = $clog2(SW + DEPTH + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FLUSH, DONE} state_t;

  state_t           state, state_d;
  logic             winner, win_d, prefer1;
  logic             gnt0_d, gnt1_d;
  logic [CW-1:0]    cnt;
  logic [SW-1:0]    word, load_word;
  logic [WIDTH-1:0] sel_din;
  logic [DEPTH-1:0] ch_data, ch_valid;
  logic             in_data, in_valid;

  // Word presented by the recorded winner, with the optional parity bit appended
  assign sel_din = winner ? din1 : din0;
`ifdef SHIFT_ARB_PARITY_EN
  assign load_word = {sel_din, ^sel_din};
`else
  assign load_word = sel_din;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, arbitration and chain input
  always_comb begin
    state_d  = state;
    win_d    = winner;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    in_data  = 1'b0;
    in_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_d = LOAD;
          win_d   = (req0 & req1) ? prefer1 : req1;
          gnt0_d  = ~win_d;
          gnt1_d  = win_d;
        end
      end
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        in_data  = word[SW-1];
        in_valid = 1'b1;
        if (cnt == CW'(SW - 1)) state_d = FLUSH;
      end
      FLUSH: if (cnt == CW'(DEPTH - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, serial chain and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner   <= 1'b0;
      prefer1  <= 1'b0;
      cnt      <= '0;
      word     <= '0;
      ch_data  <= '0;
      ch_valid <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (state == IDLE && state_d == LOAD) begin
        winner  <= win_d;
        prefer1 <= ~win_d;
      end
      if (state_d != state) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
      if (state == LOAD)       word <= load_word;
      else if (state == SHIFT) word <= word << 1;
      ch_data[0]  <= in_data;
      ch_valid[0] <= in_valid;
      for (int i = 1; i < int'(DEPTH); i++) begin
        ch_data[i]  <= ch_data[i-1];
        ch_valid[i] <= ch_valid[i-1];
      end
      gnt0 <= gnt0_d;
      gnt1 <= gnt1_d;
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
    end
  end

  // Invalid stages always carry data 0, so the tail needs no masking
  assign q       = ch_data[DEPTH-1];
  assign q_valid = ch_valid[DEPTH-1];

endmodule

// File: tb/tb_shift_arb.sv
// Directed self-checking bench for shift_arb (default parameters, parity build optional).
module tb_shift_arb;

`ifdef SHIFT_ARB_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       gnt0, gnt1, busy, q, q_valid, done;
  int         checks = 0;
  int         failures = 0;

  shift_arb #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .q(q), .q_valid(q_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial sequence, right-aligned, first bit in the highest used position
  function automatic logic [8:0] exp_bits(input logic [7:0] d);
    if (PAR != 0) return {d, ^d};
    return {1'b0, d};
  endfunction

  // Observe one transfer; mode 0 drops the winner's req at its grant,
  // mode 1 toggles both reqs randomly while busy and clears them at done.
  task automatic run_xfer(input string tag, input int wg, input logic [7:0] d, input int mode);
    int g0 = 0, g1 = 0, both = 0, nb = 0, bc = 0, qbad = 0;
    logic [8:0] bits = '0;
    bit fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (gnt0) g0++;
      if (gnt1) g1++;
      if (busy) bc++;
      if (q_valid) begin
        bits = {bits[7:0], q};
        nb++;
      end else if (q !== 1'b0) qbad++;
      if (gnt0 || gnt1) begin
        if (gnt0) req0 = 1'b0;
        if (gnt1) req1 = 1'b0;
      end else if (mode == 1 && busy && !done) begin
        req0 = 1'($urandom_range(1, 0));
        req1 = 1'($urandom_range(1, 0));
      end
      if (done) begin
        fin = 1'b1;
        if (mode == 1) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    chk({tag, "_done"}, 32'(fin), 32'd1);
    chk({tag, "_gnt_win"}, 32'(wg == 0 ? g0 : g1), 32'd1);
    chk({tag, "_gnt_lose"}, 32'(wg == 0 ? g1 : g0), 32'd0);
    chk({tag, "_gnt_both"}, 32'(both), 32'd0);
    chk({tag, "_bits"}, 32'(bits), 32'(exp_bits(d)));
    chk({tag, "_nvalid"}, 32'(nb), 32'(8 + PAR));
    chk({tag, "_busy"}, 32'(bc), 32'(12 + PAR));
    chk({tag, "_q_zero"}, 32'(qbad), 32'd0);
  endtask

  initial begin
    int stray;
    #1;
    chk("reset_outs", 32'({gnt0, gnt1, busy, q, q_valid, done}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Tie straight after reset: requester 0 first, then 1
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h0F; din1 = 8'hF0;
    run_xfer("tie0", 0, 8'h0F, 0);
    run_xfer("tie1", 1, 8'hF0, 0);

    req0 = 1'b1; din0 = 8'hA5;
    run_xfer("a5", 0, 8'hA5, 0);

    // Requester 1 twice, then a tie goes to requester 0; reqs churn while busy
    req1 = 1'b1; din1 = 8'h3C;
    run_xfer("r1a", 1, 8'h3C, 0);
    req1 = 1'b1; din1 = 8'hC3;
    run_xfer("r1b", 1, 8'hC3, 0);
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h5A;
    run_xfer("rr_tie", 0, 8'h5A, 1);

    req0 = 1'b1; din0 = 8'h07;
    run_xfer("x07", 0, 8'h07, 0);

    // Reset in SHIFT cycle 4 aborts the transfer
    @(negedge clk);
    req0 = 1'b1; din0 = 8'hFF;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_qv_before", 32'({q_valid, q}), 32'd3);
    rst = 1'b1;
    #1;
    chk("abort_outs", 32'({gnt0, gnt1, busy, q, q_valid, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (q_valid || done || busy || gnt0 || gnt1) stray++;
    end
    chk("abort_quiet", 32'(stray), 32'd0);
    req0 = 1'b1;
    run_xfer("post_rst", 0, 8'hFF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
